// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic FIR sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Package contents: controller state enum, default SIZE/TAPS, result counter width.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int SIZE_DEF  = 8;
  localparam int TAPS_DEF  = 4;
  localparam int RES_CNT_W = 16;

endpackage

// File: rtl/systolic_result_fifo.sv
// Synchronous result FIFO between the systolic array tail and the result stream.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: never refuses a push; the caller reserves space in advance.
//
// Ports: clk/rst (async active-high), push_i/data_i write side,
//        pop_i read side, data_o head (0 while empty), count_o/empty_o/full_o status.
module systolic_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= ptr_next(wr_q);
      end
      if (pop_i) begin
        rd_q <= ptr_next(rd_q);
      end
      if (push_i && !pop_i) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!push_i && pop_i) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  // Head is forced to zero while empty so the stream data is defined out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Space is reserved before a sample enters the array, so a full FIFO must never see a push.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/systolic_fir_ctrl.sv
// Sequencer for a linear systolic MAC array: coefficient bank, sample feed, result buffering.
// Latency: sample accepted at edge 0 appears on m_data after edge TAPS (FIFO empty).
// Backpressure: s_ready drops when FIFO occupancy plus results in flight reaches FIFO_DEPTH.
//
// Ports: clk, reset (async active-high); cfg_wr/cfg_addr/cfg_data coefficient writes,
//        start/stop FSM pulses, busy/cfg_err status; s_* sample stream in, m_* result
//        stream out; arr_reset/arr_x/arr_coeff drive the array, arr_y is its tail output;
//        res_cnt counts result pops when SYSTOLIC_CTRL_CNT_EN is defined, else reads 0.
module systolic_fir_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int TAPS       = TAPS_DEF,
  parameter int FIFO_DEPTH = TAPS + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_wr,
  input  logic [$clog2(TAPS)-1:0] cfg_addr,
  input  logic [SIZE-1:0]         cfg_data,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    cfg_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SIZE-1:0]         s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*SIZE-1:0]       m_data,
  output logic                    arr_reset,
  output logic [SIZE-1:0]         arr_x,
  output logic [TAPS*SIZE-1:0]    arr_coeff,
  input  logic [2*SIZE-1:0]       arr_y,
  output logic [RES_CNT_W-1:0]    res_cnt
);

  localparam int IW = $clog2(TAPS + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  state_e          state_q;
  logic            busy_q;
  logic            arr_reset_q;
  logic            cfg_err_q;
  logic [SIZE-1:0] coeff_q [TAPS];
  logic [TAPS-1:0] vld_q;
  logic [IW-1:0]   inflight_q;

  logic            addr_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_empty;
  logic            fifo_full;

  // Only meaningful when TAPS is not a power of two; otherwise every address is valid.
  assign addr_ok = (int'(cfg_addr) < TAPS);

  // Credit check counts results already in flight so the array never has to stall.
  // The full test is implied by the credit sum and kept as a belt-and-braces guard.
  assign s_ready = (state_q == ST_RUN) && !fifo_full &&
                   ((SW'(fifo_cnt) + SW'(inflight_q)) < SW'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign push    = vld_q[TAPS-1];
  assign pop     = !fifo_empty && m_ready;
  assign m_valid = !fifo_empty;

  // Idle cycles feed a zero bubble so stale data never enters the head PE.
  assign arr_x = accept ? s_data : '0;

  always_comb begin
    arr_coeff = '0;
    for (int k = 0; k < TAPS; k++) begin
      arr_coeff[k*SIZE +: SIZE] = coeff_q[k];
    end
  end

  assign busy      = busy_q;
  assign arr_reset = arr_reset_q;
  assign cfg_err   = cfg_err_q;

  // FSM, coefficient bank and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CFG;
      busy_q      <= 1'b0;
      arr_reset_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coeff_q[k] <= '0;
      end
    end else begin
      cfg_err_q <= cfg_wr && ((state_q != ST_CFG) || !addr_ok);
      // Write is applied even when start arrives in the same cycle.
      if (cfg_wr && (state_q == ST_CFG) && addr_ok) begin
        coeff_q[cfg_addr] <= cfg_data;
      end
      case (state_q)
        ST_CFG: begin
          if (start) begin
            state_q     <= ST_CLEAR;
            busy_q      <= 1'b1;
            arr_reset_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_RUN;
          arr_reset_q <= 1'b0;
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_q == '0) && fifo_empty) begin
            state_q     <= ST_CFG;
            busy_q      <= 1'b0;
            arr_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_CFG;
          busy_q      <= 1'b0;
          arr_reset_q <= 1'b1;
        end
      endcase
    end
  end

  // Valid tracking mirrors the array pipeline; inflight is its popcount kept incrementally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q <= {vld_q[TAPS-2:0], accept};
      if (accept && !push) begin
        inflight_q <= inflight_q + IW'(1);
      end else if (!accept && push) begin
        inflight_q <= inflight_q - IW'(1);
      end
    end
  end

  systolic_result_fifo #(
    .W     (2 * SIZE),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (arr_y),
    .pop_i   (pop),
    .data_o  (m_data),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

`ifdef SYSTOLIC_CTRL_CNT_EN
  logic [RES_CNT_W-1:0] res_cnt_q;

  // Cleared on the start edge so each run counts only its own results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_cnt_q <= '0;
    end else if ((state_q == ST_CFG) && start) begin
      res_cnt_q <= '0;
    end else if (pop) begin
      res_cnt_q <= res_cnt_q + RES_CNT_W'(1);
    end
  end

  assign res_cnt = res_cnt_q;
`else
  assign res_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_fir_ctrl.sv
module tb_systolic_fir_ctrl;

  localparam int SIZE  = 8;
  localparam int TAPS  = 4;
  localparam int DEPTH = TAPS + 2;
  localparam int S_CFG = 0, S_CLEAR = 1, S_RUN = 2, S_DRAIN = 3;
`ifdef SYSTOLIC_CTRL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, reset;
  logic        cfg_wr, start, stop, s_valid, m_ready;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_data, s_data;
  logic        busy, cfg_err, s_ready, m_valid, arr_reset;
  logic [15:0] m_data, res_cnt, arr_y;
  logic [7:0]  arr_x;
  logic [31:0] arr_coeff;

  // Second instance with TAPS=5 so an out-of-range address is expressible.
  logic        c5_wr;
  logic [2:0]  c5_addr;
  logic [7:0]  c5_data;
  logic        c5_busy, c5_err, c5_sready, c5_mvalid, c5_arst;
  logic [15:0] c5_mdata, c5_cnt;
  logic [7:0]  c5_x;
  logic [39:0] c5_coeff;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  systolic_fir_ctrl #(.SIZE(SIZE), .TAPS(TAPS), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .busy(busy), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .arr_reset(arr_reset), .arr_x(arr_x), .arr_coeff(arr_coeff), .arr_y(arr_y),
    .res_cnt(res_cnt)
  );

  systolic_fir_ctrl #(.SIZE(8), .TAPS(5)) u_dut5 (
    .clk(clk), .reset(reset), .cfg_wr(c5_wr), .cfg_addr(c5_addr), .cfg_data(c5_data),
    .start(1'b0), .stop(1'b0), .busy(c5_busy), .cfg_err(c5_err),
    .s_valid(1'b0), .s_ready(c5_sready), .s_data(8'h00),
    .m_valid(c5_mvalid), .m_ready(1'b0), .m_data(c5_mdata),
    .arr_reset(c5_arst), .arr_x(c5_x), .arr_coeff(c5_coeff), .arr_y(16'h0000),
    .res_cnt(c5_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: y = x * sum(coeff), four register stages, synchronous clear.
  logic [15:0] pipe [4];
  always @(posedge clk) begin
    logic [15:0] s;
    s = 16'h0;
    for (int k = 0; k < TAPS; k++) s = s + 16'(arr_coeff[k*8 +: 8]);
    if (arr_reset) begin
      for (int k = 0; k < 4; k++) pipe[k] <= 16'h0;
    end else begin
      pipe[0] <= 16'(s * 16'(arr_x));
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign arr_y = pipe[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [15:0] val; int due; } infl_t;
  infl_t       m_infl[$];
  logic [15:0] m_fifo[$];
  logic [7:0]  m_coeff [4];
  int          m_state;
  bit          m_cfg_err;
  logic [15:0] m_cnt;
  int          m_cyc = 0;

  function automatic bit m_sready();
    return (m_state == S_RUN) && ((m_fifo.size() + m_infl.size()) < DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state   = S_CFG;
      m_infl.delete();
      m_fifo.delete();
      for (int k = 0; k < 4; k++) m_coeff[k] = 8'h0;
      m_cfg_err = 1'b0;
      m_cnt     = 16'h0;
    end else begin
      bit acc, pop, idle;
      int sum;
      infl_t t;
      acc  = s_valid && m_sready();
      pop  = m_ready && (m_fifo.size() != 0);
      idle = (m_fifo.size() == 0) && (m_infl.size() == 0);
      sum  = 0;
      for (int k = 0; k < 4; k++) sum += int'(m_coeff[k]);
      m_cfg_err = cfg_wr && (m_state != S_CFG || int'(cfg_addr) >= TAPS);
      if (cfg_wr && m_state == S_CFG && int'(cfg_addr) < TAPS) m_coeff[cfg_addr] = cfg_data;
      if (pop) begin
        void'(m_fifo.pop_front());
        m_cnt = m_cnt + 16'h1;
      end
      while (m_infl.size() != 0 && m_infl[0].due == m_cyc) begin
        t = m_infl.pop_front();
        m_fifo.push_back(t.val);
      end
      if (acc) begin
        t.val = 16'(int'(s_data) * sum);
        t.due = m_cyc + TAPS;
        m_infl.push_back(t);
      end
      case (m_state)
        S_CFG:   if (start) begin m_state = S_CLEAR; m_cnt = 16'h0; end
        S_CLEAR: m_state = S_RUN;
        S_RUN:   if (stop) m_state = S_DRAIN;
        default: if (idle) m_state = S_CFG;
      endcase
      m_cyc++;
    end
  end

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit esr;
      esr = m_sready();
      chk("busy",      64'(busy),      64'(m_state != S_CFG));
      chk("arr_reset", 64'(arr_reset), 64'(m_state == S_CFG || m_state == S_CLEAR));
      chk("cfg_err",   64'(cfg_err),   64'(m_cfg_err));
      chk("s_ready",   64'(s_ready),   64'(esr));
      chk("arr_x",     64'(arr_x),     64'((s_valid && esr) ? s_data : 8'h0));
      chk("m_valid",   64'(m_valid),   64'(m_fifo.size() != 0));
      chk("m_data",    64'(m_data),    64'((m_fifo.size() != 0) ? m_fifo[0] : 16'h0));
      chk("arr_coeff", 64'(arr_coeff), 64'({m_coeff[3], m_coeff[2], m_coeff[1], m_coeff[0]}));
      chk("res_cnt",   64'(res_cnt),   64'(CNT_EN ? m_cnt : 16'h0));
    end
  end

  // Stream monitors (sampled mid-cycle, transfer happens at the next rising edge).
  int cyc = 0, pop_cnt = 0, acc_cnt = 0, drops = 0, first_pop = -1, last_pop = -1;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (!reset && s_valid && s_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < lim) begin tick(); n++; end
    @(negedge clk);
    chk(name, 64'(busy), 64'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cfg_wr = 0; cfg_addr = 0; cfg_data = 0; start = 0; stop = 0;
    s_valid = 0; s_data = 0; m_ready = 0; c5_wr = 0; c5_addr = 0; c5_data = 0;
    #2 reset = 1'b1;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_s_ready",   64'(s_ready),   64'd0);
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_m_data",    64'(m_data),    64'd0);
    chk("rst_arr_reset", 64'(arr_reset), 64'd1);
    chk("rst_arr_coeff", 64'(arr_coeff), 64'd0);
    chk("rst_res_cnt",   64'(res_cnt),   64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Out-of-range address on the TAPS=5 instance.
    c5_wr = 1; c5_addr = 3'd1; c5_data = 8'h07;
    tick(); c5_wr = 0;
    @(negedge clk);
    chk("c5_ok_err",   64'(c5_err),   64'd0);
    chk("c5_ok_coeff", 64'(c5_coeff), 64'h00_0000_0700);
    tick();
    c5_wr = 1; c5_addr = 3'd5; c5_data = 8'h09;
    tick(); c5_wr = 0;
    @(negedge clk);
    chk("c5_bad_err",   64'(c5_err),   64'd1);
    chk("c5_bad_coeff", 64'(c5_coeff), 64'h00_0000_0700);
    tick();
    @(negedge clk);
    chk("c5_err_pulse", 64'(c5_err), 64'd0);
    tick();

    // Single sample through coefficients 1,2,3,4.
    cfg_write(2'd0, 8'd1); cfg_write(2'd1, 8'd2); cfg_write(2'd2, 8'd3); cfg_write(2'd3, 8'd4);
    @(negedge clk);
    chk("coeff_load", 64'(arr_coeff), 64'h04030201);
    tick();
    do_start();
    @(negedge clk);
    chk("run_arr_reset", 64'(arr_reset), 64'd0);
    chk("run_s_ready",   64'(s_ready),   64'd1);
    tick();
    m_ready = 1; s_valid = 1; s_data = 8'd5;
    tick();
    s_valid = 0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("lat_early_mvalid", 64'(m_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("lat_mvalid", 64'(m_valid), 64'd1);
    chk("lat_mdata",  64'(m_data),  64'd50);
    tick(); tick();
    @(negedge clk);
    chk("cnt_after_one", 64'(res_cnt), CNT_EN ? 64'd1 : 64'd0);
    tick();

    // Ten back-to-back samples with the sink always ready.
    pop_cnt = 0; first_pop = -1; drops = 0;
    s_valid = 1;
    for (int i = 0; i < 10; i++) begin
      s_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (!s_ready) drops++;
      tick();
    end
    s_valid = 0;
    repeat (12) tick();
    chk("stream_drops", 64'(drops), 64'd0);
    chk("stream_pops",  64'(pop_cnt), 64'd10);
    chk("stream_rate",  64'(last_pop - first_pop), 64'd9);

    // Sink stalled: exactly DEPTH samples are admitted.
    m_ready = 0; acc_cnt = 0; s_valid = 1;
    repeat (12) begin
      s_data = 8'($urandom_range(0, 255));
      tick();
    end
    s_valid = 0;
    @(negedge clk);
    chk("bp_accepts", 64'(acc_cnt), 64'd6);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    tick();
    pop_cnt = 0; m_ready = 1;
    repeat (20) tick();
    chk("bp_drained", 64'(pop_cnt), 64'd6);

    // Coefficient write while running is rejected.
    cfg_write(2'd0, 8'h99);
    @(negedge clk);
    chk("run_wr_err",   64'(cfg_err),   64'd1);
    chk("run_wr_coeff", 64'(arr_coeff), 64'h04030201);
    tick();
    @(negedge clk);
    chk("run_wr_pulse", 64'(cfg_err), 64'd0);
    tick();

    // Stop with three results still in the array.
    pop_cnt = 0; s_valid = 1;
    repeat (3) begin s_data = 8'($urandom_range(0, 255)); tick(); end
    s_valid = 0; stop = 1;
    tick();
    stop = 0;
    @(negedge clk);
    chk("drain_busy",    64'(busy),    64'd1);
    chk("drain_s_ready", 64'(s_ready), 64'd0);
    tick();
    wait_idle("drain_idle", 40);
    chk("drain_pops", 64'(pop_cnt), 64'd3);

    // Randomised runs, last coefficient write coinciding with start.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) cfg_write(2'(k), 8'($urandom_range(0, 255)));
      start = 1;
      cfg_write(2'd3, 8'($urandom_range(0, 255)));
      start = 0;
      tick();
      for (int i = 0; i < 150; i++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = 8'($urandom_range(0, 255));
        m_ready = ($urandom_range(0, 3) != 0);
        cfg_wr  = ($urandom_range(0, 19) == 0);
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_data = 8'($urandom_range(0, 255));
        start   = ($urandom_range(0, 29) == 0);
        tick();
      end
      s_valid = 0; cfg_wr = 0; start = 0; stop = 1;
      tick();
      stop = 0; m_ready = 1;
      wait_idle("rand_idle", 60);
    end

    // Reset in RUN with two results held in the FIFO.
    cfg_write(2'd0, 8'd1); cfg_write(2'd1, 8'd2); cfg_write(2'd2, 8'd3); cfg_write(2'd3, 8'd4);
    do_start();
    m_ready = 1; s_valid = 1; s_data = 8'd3;
    tick();
    s_valid = 0;
    repeat (6) tick();
    m_ready = 0; s_valid = 1; s_data = 8'd7;
    tick(); tick();
    s_valid = 0;
    repeat (6) tick();
    @(negedge clk);
    chk("pre_rst_mvalid", 64'(m_valid), 64'd1);
    chk("pre_rst_cnt",    64'(res_cnt), CNT_EN ? 64'd1 : 64'd0);
    tick();
    reset = 1;
    @(negedge clk);
    chk("mid_rst_mvalid", 64'(m_valid),   64'd0);
    chk("mid_rst_busy",   64'(busy),      64'd0);
    chk("mid_rst_coeff",  64'(arr_coeff), 64'd0);
    chk("mid_rst_cnt",    64'(res_cnt),   64'd0);
    chk("mid_rst_arst",   64'(arr_reset), 64'd1);
    tick();
    reset = 0;
    repeat (3) tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_fir_ctrl.md
# systolic_fir_ctrl

Sequencer for a linear systolic array of `TAPS` multiply-accumulate PEs. It loads the per-PE coefficients and feeds samples into the head of the array through a valid/ready stream. The array cannot stall, so the block tracks results in flight with a valid shift register. It buffers results in a credit-protected FIFO so downstream backpressure never drops a result.

## Interface
Parameters:
- `SIZE`, 8, sample/coefficient width; results are `2*SIZE` wide
- `TAPS`, 4, number of PEs in the array (≥2)
- `FIFO_DEPTH`, `TAPS+2`, result FIFO entries (≥`TAPS`)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `cfg_wr` in 1: coefficient write strobe
- `cfg_addr` in `$clog2(TAPS)`: PE index
- `cfg_data` in `SIZE`: coefficient value
- `start` in 1: pulse, CFG→CLEAR
- `stop` in 1: pulse, RUN→DRAIN
- `busy` out 1: state ≠ CFG
- `cfg_err` out 1: one-cycle pulse on an ignored `cfg_wr`
- `s_valid` in 1, `s_ready` out 1, `s_data` in `SIZE`: sample stream
- `m_valid` out 1, `m_ready` in 1, `m_data` out `2*SIZE`: result stream
- `arr_reset` out 1: synchronous reset to all PEs
- `arr_x` out `SIZE`: head-PE x input
- `arr_coeff` out `TAPS*SIZE`: flattened coefficients; PE k uses bits `[k*SIZE +: SIZE]`
- `arr_y` in `2*SIZE`: tail-PE y output
- `res_cnt` out 16: result count (see Configuration)

## Operation
- States:
  - CFG: reset state.
    - `cfg_wr` writes `coeff[cfg_addr]`; a write with `cfg_addr ≥ TAPS` is ignored and pulses `cfg_err`.
    - `start` → CLEAR.
  - CLEAR: exactly one cycle, then → RUN.
  - RUN: accepts samples. `stop` → DRAIN.
  - DRAIN: no accepts. → CFG when `inflight == 0` and the FIFO is empty.
- `cfg_wr` outside CFG is ignored and pulses `cfg_err`; the coefficients are unchanged. `start` outside CFG and `stop` outside RUN are ignored.
- Simultaneous `cfg_wr` and `start` in CFG: the write takes effect, then the transition.
- `arr_reset` is high in CFG and CLEAR, low in RUN and DRAIN.
- Accept: `s_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH)`. Accept occurs on `s_valid && s_ready`.
  - `arr_x = accept ? s_data : 0` (combinational); otherwise a bubble is inserted.
- Valid shift register `vld[TAPS-1:0]`: `vld[0] <= accept`, shifts once per cycle. When `vld[TAPS-1]` is high, `arr_y` is written to the FIFO.
- `inflight` = popcount of `vld`, kept as a counter: +1 on accept, −1 on FIFO write; both in the same cycle leaves it unchanged.
- FIFO: `m_valid = !empty`, `m_data` = head. Pop on `m_valid && m_ready`. Simultaneous push and pop keeps the count. The credit rule guarantees no push when full; an overflow is an assertion failure.
- `stop` while samples are in flight: all in-flight results still reach the FIFO and drain out.
- Async `reset` mid-operation has the same effect as power-on reset.

## Timing
- Reset values:
  - state = CFG
  - `busy` = 0, `cfg_err` = 0, `s_ready` = 0, `m_valid` = 0
  - `m_data` = 0, `arr_x` = 0, `arr_reset` = 1
  - all coefficients 0, `vld` = 0, `inflight` = 0, FIFO empty, `res_cnt` = 0
- `arr_coeff` is registered: a write is visible the cycle after `cfg_wr`.
- Latency: a sample accepted at edge 0 sets `m_valid` after edge `TAPS` (FIFO empty, `m_ready` high).
- Throughput is one sample per cycle when `m_ready` is held high.
- `busy` falls on the same edge that enters CFG from DRAIN.

## Configuration
- Macro `SYSTOLIC_CTRL_CNT_EN`:
  - Defined: `res_cnt` is a 16-bit counter of FIFO pops. It wraps at 0xFFFF→0 and is cleared by `reset` and on entry to CLEAR.
  - Undefined: `res_cnt` is tied to 0 and no counter logic is generated.

## Structure
- Package `systolic_ctrl_pkg`: state enum (`ST_CFG`, `ST_CLEAR`, `ST_RUN`, `ST_DRAIN`), default `SIZE`/`TAPS` constants, and the `RES_CNT_W = 16` constant.
- Sub-module `systolic_result_fifo`: synchronous FIFO (width `2*SIZE`, depth `FIFO_DEPTH`) with count, empty and full outputs.
- The controller holds the FSM, coefficient bank, valid shift register and credit logic.

## Test plan
All scenarios use `TAPS=4` and an array model computing result = x·Σcoeff with a 4-cycle latency.
- Load coeffs 1, 2, 3, 4; `start`; one sample 5 → `m_data` = 50, `m_valid` high 4 cycles after accept; `arr_reset` low from RUN.
- Stream of 10 samples with `m_ready` = 1 → `s_ready` never drops, and 10 results in order at 1 per cycle.
- Hold `m_ready` = 0 and stream samples → `s_ready` falls after exactly 6 accepts; release → all 6 results delivered, no loss or overflow.
- `cfg_wr` in RUN, and a write with `cfg_addr` = 5 in CFG → each pulses `cfg_err`; coefficients unchanged.
- `stop` with 3 samples in flight → DRAIN; 3 results delivered; `busy` falls once the FIFO is empty.
- Assert `reset` mid-RUN with the FIFO holding 2 entries → `m_valid` = 0, state CFG, coefficients 0; `res_cnt` = 0 when `SYSTOLIC_CTRL_CNT_EN` is defined.
